gpp: RTL and testbench



---
 rtl/gpp_pkg.sv | 30 +++
 rtl/gpp_regfile.sv | 34 +++
 rtl/gpp.sv | 151 +++++++++++++++
 tb/tb_gpp.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpp_pkg.sv
// Shared definitions for the gpp core: width defaults, opcode/funct encodings, FSM states.
package gpp_pkg;

  localparam int unsigned GPP_D_WIDTH  = 32;
  localparam int unsigned GPP_SA_WIDTH = 8;
  localparam int unsigned GPP_RA_WIDTH = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_INIT,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_STORE,
    S_DONE
  } state_t;

endpackage

// File: rtl/gpp_regfile.sv
// Register file: 2 asynchronous read ports, 1 synchronous write port, register 0 hardwired to zero.
module gpp_regfile
  import gpp_pkg::*;
#(
  parameter int unsigned D_WIDTH  = GPP_D_WIDTH,
  parameter int unsigned RA_WIDTH = GPP_RA_WIDTH
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic [RA_WIDTH-1:0] ra1,
  input  logic [RA_WIDTH-1:0] ra2,
  output logic [D_WIDTH-1:0]  rd1,
  output logic [D_WIDTH-1:0]  rd2,
  input  logic                we,
  input  logic [RA_WIDTH-1:0] wa,
  input  logic [D_WIDTH-1:0]  wd
);

  localparam int unsigned NREGS = 2 ** RA_WIDTH;

  logic [D_WIDTH-1:0] regs [NREGS];

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/gpp.sv
// Multi-cycle MIPS-subset core fetching from an external synchronous SRAM.
// Optional BEQ/BNE support is enabled by defining GPP_BRANCH_EN.
module gpp
  import gpp_pkg::*;
#(
  parameter int unsigned D_WIDTH  = GPP_D_WIDTH,
  parameter int unsigned SA_WIDTH = GPP_SA_WIDTH,
  parameter int unsigned RA_WIDTH = GPP_RA_WIDTH
) (
  input  logic                Clk,
  input  logic                Rst,
  output logic [SA_WIDTH-1:0] Addr,
  input  logic [D_WIDTH-1:0]  Data,
  output logic                RW,
  output logic                En,
  output logic                Done
);

  state_t              state;
  logic [SA_WIDTH-1:0] pc;
  logic [D_WIDTH-1:0]  ir;
  logic [D_WIDTH-1:0]  a_r, b_r, res_r;
  logic                wb_en_r, taken_r;
  logic [RA_WIDTH-1:0] wb_addr_r;

  logic [D_WIDTH-1:0]  rd1, rd2;
  logic [D_WIDTH-1:0]  imm_sext, imm_zext;
  logic [D_WIDTH-1:0]  exec_res;
  logic                exec_wb, exec_taken;
  logic [RA_WIDTH-1:0] exec_wa;
  logic [SA_WIDTH-1:0] pc_next;

  assign RW = 1'b1;

  // Operands are read straight from the SRAM word during decode, in parallel with the IR latch.
  gpp_regfile #(
    .D_WIDTH (D_WIDTH),
    .RA_WIDTH(RA_WIDTH)
  ) u_rf (
    .Clk(Clk),
    .Rst(Rst),
    .ra1(Data[25:21]),
    .ra2(Data[20:16]),
    .rd1(rd1),
    .rd2(rd2),
    .we (state == S_STORE && wb_en_r),
    .wa (wb_addr_r),
    .wd (res_r)
  );

  assign imm_sext = {{(D_WIDTH-16){ir[15]}}, ir[15:0]};
  assign imm_zext = {{(D_WIDTH-16){1'b0}}, ir[15:0]};

  always_comb begin
    exec_res   = '0;
    exec_wb    = 1'b0;
    exec_wa    = ir[15:11];
    exec_taken = 1'b0;
    case (ir[31:26])
      OP_RTYPE: begin
        exec_wb = 1'b1;
        case (ir[5:0])
          FN_ADD:  exec_res = a_r + b_r;
          FN_SUB:  exec_res = a_r - b_r;
          FN_AND:  exec_res = a_r & b_r;
          FN_OR:   exec_res = a_r | b_r;
          FN_SLT:  exec_res = {{(D_WIDTH-1){1'b0}}, ($signed(a_r) < $signed(b_r))};
          default: exec_wb  = 1'b0;
        endcase
      end
      OP_ADDI: begin
        exec_res = a_r + imm_sext;
        exec_wb  = 1'b1;
        exec_wa  = ir[20:16];
      end
      OP_ORI: begin
        exec_res = a_r | imm_zext;
        exec_wb  = 1'b1;
        exec_wa  = ir[20:16];
      end
`ifdef GPP_BRANCH_EN
      OP_BEQ: exec_taken = (a_r == b_r);
      OP_BNE: exec_taken = (a_r != b_r);
`else
`endif
      default: ;
    endcase
  end

  assign pc_next = pc + SA_WIDTH'(1) + (taken_r ? imm_sext[SA_WIDTH-1:0] : '0);

  // Addr/En are registered and loaded on entry to S_FETCH so the SRAM samples them on the fetch edge.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= S_INIT;
      pc        <= '0;
      ir        <= '0;
      a_r       <= '0;
      b_r       <= '0;
      res_r     <= '0;
      wb_en_r   <= 1'b0;
      wb_addr_r <= '0;
      taken_r   <= 1'b0;
      Addr      <= '0;
      En        <= 1'b0;
      Done      <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          Addr  <= pc;
          En    <= 1'b1;
          state <= S_FETCH;
        end
        S_FETCH: begin
          En    <= 1'b0;
          state <= S_DECODE;
        end
        S_DECODE: begin
          ir  <= Data;
          a_r <= rd1;
          b_r <= rd2;
          if (Data[31:26] == OP_HALT) begin
            Done  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          res_r     <= exec_res;
          wb_en_r   <= exec_wb;
          wb_addr_r <= exec_wa;
          taken_r   <= exec_taken;
          state     <= S_STORE;
        end
        S_STORE: begin
          pc    <= pc_next;
          Addr  <= pc_next;
          En    <= 1'b1;
          state <= S_FETCH;
        end
        S_DONE: begin
          En   <= 1'b0;
          Done <= 1'b1;
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_gpp.sv
// Self-checking bench for gpp: SRAM model plus an instruction-level reference interpreter.
module tb_gpp;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [7:0]  Addr;
  logic [31:0] Data = '0;
  logic        RW, En, Done;

  logic [31:0] mem   [256];
  logic [31:0] exp_r [32];
  int          exp_edges;
  int          total = 0;
  int          bad   = 0;

  localparam logic [31:0] HALT = 32'hFC000000;

  gpp #(.D_WIDTH(32), .SA_WIDTH(8), .RA_WIDTH(5)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .Addr(Addr),
    .Data(Data),
    .RW  (RW),
    .En  (En),
    .Done(Done)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) if (En && RW) Data <= mem[Addr];

  task automatic load(input logic [31:0] p [$]);
    for (int i = 0; i < 256; i++) mem[i] = HALT;
    for (int i = 0; i < p.size(); i++) mem[i] = p[i];
  endtask

  // Instruction-level interpreter: runs from address 0 until halt.
  task automatic model();
    logic [31:0] r [32];
    logic [7:0]  pc, npc;
    logic [31:0] ins, a, b, imms;
    int          k;
    for (int i = 0; i < 32; i++) r[i] = '0;
    pc = '0;
    k  = 0;
    for (int s = 0; s < 4000; s++) begin
      ins = mem[pc];
      if (ins[31:26] == 6'h3F) break;
      a    = r[ins[25:21]];
      b    = r[ins[20:16]];
      imms = {{16{ins[15]}}, ins[15:0]};
      npc  = pc + 8'd1;
      case (ins[31:26])
        6'h00: case (ins[5:0])
          6'h20: r[ins[15:11]] = a + b;
          6'h22: r[ins[15:11]] = a - b;
          6'h24: r[ins[15:11]] = a & b;
          6'h25: r[ins[15:11]] = a | b;
          6'h2A: r[ins[15:11]] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: ;
        endcase
        6'h08: r[ins[20:16]] = a + imms;
        6'h0D: r[ins[20:16]] = a | {16'h0, ins[15:0]};
`ifdef GPP_BRANCH_EN
        6'h04: if (a == b) npc = pc + 8'd1 + imms[7:0];
        6'h05: if (a != b) npc = pc + 8'd1 + imms[7:0];
`endif
        default: ;
      endcase
      r[0] = '0;
      pc   = npc;
      k++;
    end
    for (int i = 0; i < 32; i++) exp_r[i] = r[i];
    exp_edges = 4 * k + 3;
  endtask

  task automatic reset_release();
    @(negedge Clk);
    Rst = 1'b0;
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
  endtask

  task automatic wait_done(input string name, input int start);
    int n;
    n = start;
    while (Done !== 1'b1 && n < exp_edges + 20) begin
      @(posedge Clk);
      #1;
      n++;
    end
    total++;
    if (Done !== 1'b1 || n != exp_edges) begin
      bad++;
      $display("FAIL %s done_edge got=%0d (Done=%b) want=%0d", name, n, Done, exp_edges);
    end
    for (int i = 0; i < 32; i++) begin
      total++;
      if (dut.u_rf.regs[i] !== exp_r[i]) begin
        bad++;
        $display("FAIL %s reg%0d got=%h want=%h", name, i, dut.u_rf.regs[i], exp_r[i]);
      end
    end
    repeat (3) @(posedge Clk);
    #1;
    total++;
    if (Done !== 1'b1 || En !== 1'b0) begin
      bad++;
      $display("FAIL %s done_hold Done=%b En=%b want Done=1 En=0", name, Done, En);
    end
  endtask

  task automatic run(input string name, input logic [31:0] p [$]);
    load(p);
    model();
    reset_release();
    wait_done(name, 0);
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (Addr !== 8'h00 || En !== 1'b0 || RW !== 1'b1 || Done !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got Addr=%h En=%b RW=%b Done=%b want 00 0 1 0", Addr, En, RW, Done);
    end
  endtask

  task automatic test_basic();
    logic [31:0] p [$];
    p = '{32'h20010005, 32'h2002FFFD, 32'h00221820, HALT};
    run("basic", p);
    total++;
    if (exp_edges != 15 || exp_r[3] !== 32'd2 || exp_r[2] !== 32'hFFFFFFFD) begin
      bad++;
      $display("FAIL basic_model got edges=%0d r3=%h want 15 00000002", exp_edges, exp_r[3]);
    end
  endtask

  task automatic test_slt_sub();
    logic [31:0] p [$];
    p = '{32'h20010005, 32'h2002FFFD, 32'h00221820, 32'h0041202A, 32'h00222822, HALT};
    run("slt_sub", p);
    total++;
    if (dut.u_rf.regs[4] !== 32'd1 || dut.u_rf.regs[5] !== 32'd8) begin
      bad++;
      $display("FAIL slt_sub got r4=%h r5=%h want 1 8", dut.u_rf.regs[4], dut.u_rf.regs[5]);
    end
  endtask

  task automatic test_r0_ori();
    logic [31:0] p [$];
    p = '{32'h20000007, 32'h3406FFFF, HALT};
    run("r0_ori", p);
    total++;
    if (dut.u_rf.regs[0] !== 32'd0 || dut.u_rf.regs[6] !== 32'h0000FFFF) begin
      bad++;
      $display("FAIL r0_ori got r0=%h r6=%h want 0 0000ffff", dut.u_rf.regs[0], dut.u_rf.regs[6]);
    end
  endtask

  task automatic test_unknown();
    logic [31:0] p [$];
    p = '{32'h20010005, 32'hF8221800, 32'h00221801, HALT};
    run("unknown", p);
  endtask

  task automatic test_branch();
    logic [31:0] p [$];
    logic [31:0] want7;
    p = '{32'h10000001, 32'h20070001, HALT, HALT};
`ifdef GPP_BRANCH_EN
    want7 = 32'd0;
`else
    want7 = 32'd1;
`endif
    run("branch", p);
    total++;
    if (dut.u_rf.regs[7] !== want7) begin
      bad++;
      $display("FAIL branch r7 got=%h want=%h", dut.u_rf.regs[7], want7);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] p [$];
    int          any;
    p = '{32'h20010005, 32'h20020009, HALT};
    load(p);
    model();
    reset_release();
    repeat (7) @(posedge Clk);
    #1;
    Rst = 1'b0;
    #1;
    any = 0;
    for (int i = 0; i < 32; i++) if (dut.u_rf.regs[i] !== 32'd0) any++;
    total++;
    if (any != 0 || Done !== 1'b0 || En !== 1'b0 || Addr !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid nonzero_regs=%0d Done=%b En=%b Addr=%h want 0 0 0 00", any, Done, En, Addr);
    end
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    total++;
    if (Addr !== 8'h00 || En !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_refetch got Addr=%h En=%b want 00 1", Addr, En);
    end
    wait_done("reset_mid", 1);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] rs, rt, rd;
    logic [5:0] fns [5];
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    case ($urandom_range(0, 5))
      0, 1: return {6'h00, rs, rt, rd, 5'h00, fns[$urandom_range(0, 4)]};
      2, 3: return {6'h08, rs, rt, 16'($urandom)};
      4:    return {6'h0D, rs, rt, 16'($urandom)};
      default: return ($urandom_range(0, 1) == 0) ? {6'h3E, rs, rt, 16'($urandom)}
                                                  : {6'h00, rs, rt, rd, 5'h00, 6'h01};
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] p [$];
    for (int t = 0; t < 20; t++) begin
      p = {};
      for (int i = 0; i < 12; i++) p.push_back(rand_instr());
      p.push_back(HALT);
      run($sformatf("random%0d", t), p);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_slt_sub();
    test_r0_ori();
    test_unknown();
    test_branch();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
